// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder:
// FSM state encoding, default geometry and legal latency range.
package dmem_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 32;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 15;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage with one synchronous write port and
// one synchronous read port; the read register is the Q register.
module dmem_array #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // contents survive reset; only the read register is cleared
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rdata <= '0;
    else if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// SRAM-side responder for the core data port: one access at a
// time, fixed wait latency, stall handshake, access counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CEN,
  input  logic              WEN,
  input  logic              OEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q,
  output logic              stall,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_lat_chk
    $error("dmem_responder: RD_LAT out of range");
  end

  localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

  logic [1:0]        state;
  logic [3:0]        wcnt;
  logic [ADDR_W-1:0] a_lat;
  logic [DATA_W-1:0] d_lat;
  logic              wen_lat;
  logic [DATA_W-1:0] q_reg;
  logic              fire;
  logic              mem_we;
  logic              mem_re;

  // reset at the commit edge suppresses the access
  assign fire   = (state == S_WAIT) && (wcnt == 4'd0) && !rst;
  assign mem_we = fire && !wen_lat;
  assign mem_re = fire && wen_lat;

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (a_lat),
    .wdata (d_lat),
    .rdata (q_reg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      wcnt   <= 4'd0;
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!CEN) begin
            a_lat   <= A;
            d_lat   <= D;
            wen_lat <= WEN;
            wcnt    <= LAT_LOAD;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
          end else begin
            state <= S_RESP;
            if (wen_lat && rd_cnt != '1)
              rd_cnt <= rd_cnt + CNT_W'(1);
            if (!wen_lat && wr_cnt != '1)
              wr_cnt <= wr_cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall = 1'b0;
    case (state)
      S_IDLE:  stall = ~CEN;
      S_WAIT:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign Q = OEN ? '0 : q_reg;

endmodule
